fetch_packer: RTL and testbench

FETCH_PACKER -- requirements
Module: fetch_packer

---
 rtl/fetch_packer.sv | 132 +++++++++++++
 tb/tb_fetch_packer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_packer.sv
// fetch_packer: packs BEAT_W-wide fetch beats into INST_W-wide instructions,
// little-endian, with a registered output stage, stall back-pressure, flush
// with a post-flush drop window and a post-reset wait window.
// Optional macro FETCH_PACKER_PC_CHECK_EN adds a sticky pc-sequence checker.
module fetch_packer #(
    parameter int BEAT_W     = 8,
    parameter int INST_W     = 32,
    parameter int FLUSH_DROP = 1,
    parameter int RST_WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_pc,
    input  logic [BEAT_W-1:0] if_data,
    input  logic              flush,
    input  logic              stall,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              pc_err
);
    localparam int NBEAT = INST_W / BEAT_W;
    localparam int IDX_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(NBEAT - 1);
    localparam logic [2:0]       WAIT_INIT = 3'(RST_WAIT);
    localparam logic [2:0]       DROP_INIT = 3'(FLUSH_DROP);

    typedef enum logic [1:0] {WAIT, COLLECT, DROP} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [IDX_W-1:0]  idx_p0;
    logic [INST_W-1:0] part_p0;
    logic [31:0]       pc0_p0;
    logic              accept;
    logic              collect_acc;
    logic              last_beat;
    logic [INST_W-1:0] word;
    logic [31:0]       first_pc;

    // Ready: closed while waiting, open while dropping, and in COLLECT closed
    // only for the final beat when the held output cannot be replaced.
    always_comb begin
        if_ready = 1'b0;
        case (state)
            COLLECT: if_ready = !((idx_p0 == LAST) && id_valid && stall);
            DROP:    if_ready = 1'b1;
            default: if_ready = 1'b0;
        endcase
    end

    // Merge the incoming beat into the partial word and pick the word's pc.
    always_comb begin
        accept      = if_valid && if_ready;
        collect_acc = accept && (state == COLLECT);
        last_beat   = collect_acc && (idx_p0 == LAST);
        word        = part_p0;
        word[int'(idx_p0)*BEAT_W +: BEAT_W] = if_data;
        first_pc    = (idx_p0 == '0) ? if_pc : pc0_p0;
    end

    // Control FSM, beat assembly and output stage; rst beats flush beats all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (RST_WAIT == 0) ? COLLECT : WAIT;
            cnt      <= WAIT_INIT;
            idx_p0   <= '0;
            part_p0  <= '0;
            pc0_p0   <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else if (flush) begin
            state    <= (FLUSH_DROP == 0) ? COLLECT : DROP;
            cnt      <= DROP_INIT;
            idx_p0   <= '0;
            part_p0  <= '0;
            pc0_p0   <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else begin
            case (state)
                WAIT, DROP: begin
                    if (cnt <= 3'd1) state <= COLLECT;
                    else             cnt   <= cnt - 3'd1;
                end
                COLLECT: begin
                    if (collect_acc) begin
                        if (idx_p0 == LAST) begin
                            idx_p0  <= '0;
                            part_p0 <= '0;
                        end else begin
                            idx_p0  <= idx_p0 + IDX_W'(1);
                            part_p0 <= word;
                        end
                        if (idx_p0 == '0) pc0_p0 <= if_pc;
                    end
                end
                default: state <= WAIT;
            endcase
            // output stage: load on completion, hold under stall, else empty
            if (last_beat) begin
                id_valid <= 1'b1;
                id_pc    <= first_pc;
                id_inst  <= word;
            end else if (!stall) begin
                id_valid <= 1'b0;
                id_pc    <= '0;
                id_inst  <= '0;
            end
        end
    end

`ifdef FETCH_PACKER_PC_CHECK_EN
    logic [31:0] exp_pc;
    assign exp_pc = pc0_p0 + 32'(idx_p0) * 32'(BEAT_W / 8);

    // Sticky flag: any non-first beat whose pc breaks the sequence.
    always_ff @(posedge clk) begin
        if (rst)
            pc_err <= 1'b0;
        else if (!flush && collect_acc && (idx_p0 != '0) && (if_pc != exp_pc))
            pc_err <= 1'b1;
    end
`else
    assign pc_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_packer.sv
// Testbench for fetch_packer: a byte-beat instance driven from a table of
// per-cycle vectors plus hand sequences, and a 32-bit-beat instance.
module tb_fetch_packer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // byte-beat instance
    logic        rst, v, fl, st;
    logic [31:0] pc;
    logic [7:0]  d;
    logic        rdy, val, perr;
    logic [31:0] opc, oinst;

    fetch_packer #(.BEAT_W(8), .INST_W(32), .FLUSH_DROP(1), .RST_WAIT(2)) dut_a (
        .clk(clk), .rst(rst), .if_valid(v), .if_ready(rdy), .if_pc(pc),
        .if_data(d), .flush(fl), .stall(st), .id_valid(val), .id_pc(opc),
        .id_inst(oinst), .pc_err(perr)
    );

    // word-beat instance
    logic        rst_b, v_b;
    logic [31:0] pc_b, d_b;
    logic        rdy_b, val_b, perr_b;
    logic [31:0] opc_b, oinst_b;

    fetch_packer #(.BEAT_W(32), .INST_W(32), .FLUSH_DROP(1), .RST_WAIT(2)) dut_b (
        .clk(clk), .rst(rst_b), .if_valid(v_b), .if_ready(rdy_b), .if_pc(pc_b),
        .if_data(d_b), .flush(1'b0), .stall(1'b0), .id_valid(val_b), .id_pc(opc_b),
        .id_inst(oinst_b), .pc_err(perr_b)
    );

`ifdef FETCH_PACKER_PC_CHECK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, v;
        logic [31:0] pc;
        logic [7:0]  d;
        logic        fl, st;
        logic        rdy, val;
        logic [31:0] epc, einst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic vv, input logic [31:0] p,
                                input logic [7:0] dd, input logic f, input logic s,
                                input logic er, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t x;
        x.rst = r; x.v = vv; x.pc = p; x.d = dd; x.fl = f; x.st = s;
        x.rdy = er; x.val = ev; x.epc = ep; x.einst = ei;
        return x;
    endfunction

    initial begin
        rst = 1'b1; v = 1'b0; pc = '0; d = '0; fl = 1'b0; st = 1'b0;
        rst_b = 1'b1; v_b = 1'b0; pc_b = '0; d_b = '0;

        //          rst v  pc      d      fl st  rdy val pc       inst
        // reset wait, then first instruction
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 0,0,32'h0,  32'h0));
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 0,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h100,8'h13,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h101,8'h05,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h102,8'h10,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h103,8'h00,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 1,1,32'h100,32'h00100513));
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 1,0,32'h0,  32'h0));
        // stall at completion with the next word streaming in
        vecs.push_back(mk(0,1,32'h104,8'h11,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h105,8'h22,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h106,8'h33,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h107,8'h44,0,1, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h108,8'h55,0,1, 1,1,32'h104,32'h44332211));
        vecs.push_back(mk(0,1,32'h109,8'h66,0,1, 1,1,32'h104,32'h44332211));
        vecs.push_back(mk(0,1,32'h10A,8'h77,0,1, 1,1,32'h104,32'h44332211));
        vecs.push_back(mk(0,1,32'h10B,8'h88,0,1, 0,1,32'h104,32'h44332211));
        vecs.push_back(mk(0,1,32'h10B,8'h88,0,1, 0,1,32'h104,32'h44332211));
        vecs.push_back(mk(0,1,32'h10B,8'h88,0,0, 1,1,32'h104,32'h44332211));
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 1,1,32'h108,32'h88776655));
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 1,0,32'h0,  32'h0));
        // flush after two beats, one beat dropped, next word assembles
        vecs.push_back(mk(0,1,32'h200,8'hAA,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h201,8'hBB,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h202,8'hCC,1,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h300,8'hDD,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h300,8'hEF,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h301,8'hBE,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h302,8'hAD,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h303,8'hDE,0,0, 1,0,32'h0,  32'h0));
        // flush beats stall, then flush inside DROP restarts the window
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,1, 1,1,32'h300,32'hDEADBEEF));
        vecs.push_back(mk(0,0,32'h0,  8'h00,1,1, 1,1,32'h300,32'hDEADBEEF));
        vecs.push_back(mk(0,0,32'h0,  8'h00,1,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h400,8'h01,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h400,8'h01,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h401,8'h02,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h402,8'h03,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h403,8'h04,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 1,1,32'h400,32'h04030201));
        // reset after three beats discards them and re-runs the wait
        vecs.push_back(mk(0,1,32'h500,8'hA1,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h501,8'hA2,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h502,8'hA3,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(1,1,32'h503,8'hA4,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h600,8'hB1,0,0, 0,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h600,8'hB1,0,0, 0,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h600,8'hB1,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h601,8'hB2,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h602,8'hB3,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,1,32'h603,8'hB4,0,0, 1,0,32'h0,  32'h0));
        vecs.push_back(mk(0,0,32'h0,  8'h00,0,0, 1,1,32'h600,32'hB4B3B2B1));

        @(negedge clk);
        @(negedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; v = vecs[i].v; pc = vecs[i].pc; d = vecs[i].d;
            fl = vecs[i].fl; st = vecs[i].st;
            #1;
            check($sformatf("v%0d.if_ready", i), 32'(rdy), 32'(vecs[i].rdy));
            check($sformatf("v%0d.id_valid", i), 32'(val), 32'(vecs[i].val));
            check($sformatf("v%0d.id_pc", i), opc, vecs[i].epc);
            check($sformatf("v%0d.id_inst", i), oinst, vecs[i].einst);
            check($sformatf("v%0d.pc_err", i), 32'(perr), 32'h0);
        end

        // pc sequence check: third beat out of sequence
        @(negedge clk); rst = 0; fl = 0; st = 0; v = 1; pc = 32'h200; d = 8'h01;
        #1 check("pcseq.before", 32'(perr), 32'h0);
        @(negedge clk); pc = 32'h201; d = 8'h02;
        @(negedge clk); pc = 32'h205; d = 8'h03;
        #1 check("pcseq.at_bad_beat", 32'(perr), 32'h0);
        @(negedge clk); pc = 32'h203; d = 8'h04;
        #1 check("pcseq.after_bad_beat", 32'(perr), 32'(PERR_EXP));
        @(negedge clk); v = 0;
        #1;
        check("pcseq.valid", 32'(val), 32'h1);
        check("pcseq.inst", oinst, 32'h04030201);
        check("pcseq.pc", opc, 32'h200);
        @(negedge clk); fl = 1;
        #1 check("pcseq.sticky", 32'(perr), 32'(PERR_EXP));
        @(negedge clk); fl = 0; rst = 1;
        #1 check("pcseq.flush_keeps", 32'(perr), 32'(PERR_EXP));
        @(negedge clk); rst = 0;
        #1 check("pcseq.rst_clears", 32'(perr), 32'h0);

        // 32-bit beats: one instruction per beat, back to back
        @(negedge clk); rst_b = 0;
        #1 check("w32.wait1.ready", 32'(rdy_b), 32'h0);
        check("w32.reset.valid", 32'(val_b), 32'h0);
        @(negedge clk);
        #1 check("w32.wait2.ready", 32'(rdy_b), 32'h0);
        @(negedge clk); v_b = 1; pc_b = 32'h0; d_b = 32'hA;
        #1 check("w32.beat0.ready", 32'(rdy_b), 32'h1);
        @(negedge clk); pc_b = 32'h4; d_b = 32'hB;
        #1 check("w32.out0.valid", 32'(val_b), 32'h1);
        check("w32.out0.inst", oinst_b, 32'hA);
        check("w32.out0.pc", opc_b, 32'h0);
        @(negedge clk); pc_b = 32'h8; d_b = 32'hC;
        #1 check("w32.out1.valid", 32'(val_b), 32'h1);
        check("w32.out1.inst", oinst_b, 32'hB);
        @(negedge clk); v_b = 0;
        #1 check("w32.out2.valid", 32'(val_b), 32'h1);
        check("w32.out2.inst", oinst_b, 32'hC);
        check("w32.out2.pc", opc_b, 32'h8);
        check("w32.pc_err", 32'(perr_b), 32'h0);
        @(negedge clk);
        #1 check("w32.idle.valid", 32'(val_b), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
